tf_gen_ctrl: RTL
================

// Module: tf_gen_ctrl
// PURPOSE
//  Sequencer directly upstream of the twiddle-factor generator. Walks every stage l and depth row d.
//  Each step drives one read (TF_ren), waits out the Barrett multiplier latency, then one write-back (TF_wen).
//  it_depth_cnt, l and idx1..idx15 are held stable for the whole step so generator read and write hit the same row.
//  Provides start/busy/done handshake to the NTT top controller and honours a stall from the butterfly array.
// PARAMETERS
//  IT_DEPTH   3   last depth row index; rows 0..IT_DEPTH are visited
//  STAGE_NUM  4   stages visited; l runs 1..STAGE_NUM
//  BANK       15  TF banks; idx rotation modulus
//  MUL_LAT    4   barrett_reduction latency in cycles (read-issue to result valid)
// PORTS
//  clk            in   1         clock, rising edge
//  rst            in   1         asynchronous reset, active-high
//  start          in   1         1-cycle request; sampled only in IDLE
//  stall          in   1         butterfly not ready; freezes READ/WRITE issue
//  busy           out  1         high in READ, WAIT and WRITE
//  done           out  1         1-cycle pulse at end of sweep
//  TF_ren         out  1         read strobe to generator
//  TF_wen         out  1         write-back strobe to generator
//  it_depth_cnt   out  `D_width  current depth row d
//  l              out  `D_width  current stage, 1..STAGE_NUM; 0 in IDLE
//  idx1..idx15    out  `D_width  const-table index per bank k=1..15
// BEHAVIOUR
//  - Reset (async, any state, mid-sweep included):
//    - state=IDLE; all outputs 0; no done pulse.
//    - Sweep is abandoned; a new start is needed.
//  - States: IDLE, READ, WAIT, WRITE, DONE.
//    - IDLE & start: d=0, l=1 -> READ. start in any other state is ignored.
//    - READ: TF_ren=1 for exactly 1 unstalled cycle -> WAIT, wait_cnt=0.
//    - WAIT: ren=wen=0; wait_cnt++ each cycle; stall ignored (multiplier free-runs).
//      wait_cnt==MUL_LAT-1 -> WRITE.
//    - WRITE: TF_wen=1 for 1 unstalled cycle, then:
//      - d<IT_DEPTH: d++ -> READ.
//      - else d=0; l<STAGE_NUM: l++ -> READ.
//      - else -> DONE.
//    - DONE: done=1, busy=0, outputs cleared -> IDLE next cycle.
//  - Stall in READ/WRITE: strobe forced 0, state and counters hold; strobe issues on first cycle stall=0.
//  - TF_ren and TF_wen never high in the same cycle.
//  - Step = MUL_LAT+2 cycles unstalled; sweep = (IT_DEPTH+1)*STAGE_NUM steps.
//    Defaults: busy for 96 cycles, done in cycle 97 after start sampled.
//  - idx_k = ((k-1)+(l-1)) mod BANK; computed without divider (add, one conditional subtract).
//    Registered with l. Outside READ/WAIT/WRITE: idx_k=0.
//  - Counters: d/l wrap only as stated; no carry past IT_DEPTH/STAGE_NUM.
// CONFIGURATION
//  TF_GEN_CTRL_PERF_EN defined:
//    - extra output perf_stall_cnt [31:0]: counts stalled READ/WRITE cycles.
//    - Clears on start; holds after done; saturates at 32'hFFFF_FFFF; reset 0.
//  TF_GEN_CTRL_PERF_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - Package tf_pkg: state enum tf_ctrl_state_e; constants TF_BANK=15, TF_MUL_LAT=4.
//  - Sub-module tf_idx_rotate: combinational, l -> idx1..idx15 per rule above; instantiated once.
//  - Top: FSM, d/l/wait counters, output registers.
// TESTING
//  1 reset: rst pulse mid-WAIT (d=2,l=3) -> all outputs 0 same cycle, IDLE, no done; restart sweeps fine
//  2 nominal: start, stall=0 -> READ at cycles 1,7,13..; WRITE at 6,12..; done only in cycle 97
//  3 row hold: during each step it_depth_cnt/l/idx constant from READ through WRITE; d seq 0,1,2,3 per l
//  4 idx: l=1 -> idx1=0, idx15=14; l=3 -> idx1=2, idx14=0, idx15=1
//  5 stall: stall=1 3 cycles at WRITE of d=1,l=2 -> wen low 3 cycles then 1; busy 3 cycles longer;
//    perf_stall_cnt=3 when PERF_EN
//  6 start while busy ignored; start in DONE cycle ignored; ren&wen never both 1 (assertion)

Source files
------------

// File: rtl/tf_pkg.sv
// Shared types and constants for the twiddle-factor generator sequencer.
`ifndef D_width
`define D_width 4
`endif

package tf_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } tf_ctrl_state_e;

  localparam int TF_BANK    = 15;
  localparam int TF_MUL_LAT = 4;
  localparam int TF_DW      = `D_width;
endpackage

// File: rtl/tf_idx_rotate.sv
// Per-bank const-table index: idx_k = ((k-1)+(l-1)) mod TF_BANK, built from one add
// and one conditional subtract instead of a divider.
`ifndef D_width
`define D_width 4
`endif

module tf_idx_rotate
  import tf_pkg::*;
(
  input  logic [TF_DW-1:0] l_i,
  output logic [TF_DW-1:0] idx_o [TF_BANK]
);
  localparam logic [TF_DW:0] BANK_W = (TF_DW+1)'(TF_BANK);
  localparam logic [TF_DW:0] ONE_W  = (TF_DW+1)'(1);

  logic [TF_DW:0] rot;

  // l=0 only occurs while the top gates these outputs to zero; map it to rotation 0.
  assign rot = (l_i == '0) ? '0 : ({1'b0, l_i} - ONE_W);

  genvar gi;
  generate
    for (gi = 0; gi < TF_BANK; gi++) begin : g_bank
      logic [TF_DW:0] sum;
      assign sum       = (TF_DW+1)'(gi) + rot;
      assign idx_o[gi] = (sum >= BANK_W) ? TF_DW'(sum - BANK_W) : TF_DW'(sum);
    end
  endgenerate
endmodule

// File: rtl/tf_gen_ctrl.sv
// Read / wait / write-back sequencer in front of the twiddle-factor generator.
// Optional stalled-cycle counter enabled with `define TF_GEN_CTRL_PERF_EN.
`ifndef D_width
`define D_width 4
`endif

module tf_gen_ctrl
  import tf_pkg::*;
#(
  parameter int IT_DEPTH  = 3,
  parameter int STAGE_NUM = 4,
  parameter int MUL_LAT   = TF_MUL_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic             TF_ren,
  output logic             TF_wen,
  output logic [TF_DW-1:0] it_depth_cnt,
  output logic [TF_DW-1:0] l,
  output logic [TF_DW-1:0] idx1,
  output logic [TF_DW-1:0] idx2,
  output logic [TF_DW-1:0] idx3,
  output logic [TF_DW-1:0] idx4,
  output logic [TF_DW-1:0] idx5,
  output logic [TF_DW-1:0] idx6,
  output logic [TF_DW-1:0] idx7,
  output logic [TF_DW-1:0] idx8,
  output logic [TF_DW-1:0] idx9,
  output logic [TF_DW-1:0] idx10,
  output logic [TF_DW-1:0] idx11,
  output logic [TF_DW-1:0] idx12,
  output logic [TF_DW-1:0] idx13,
  output logic [TF_DW-1:0] idx14,
  output logic [TF_DW-1:0] idx15
`ifdef TF_GEN_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt
`endif
);
  tf_ctrl_state_e  state_q, state_d;
  logic [TF_DW-1:0] d_q, d_d, l_q, l_d;
  logic [7:0]       wait_q, wait_d;
  logic [TF_DW-1:0] idx_w [TF_BANK];
  logic [TF_DW-1:0] idx_g [TF_BANK];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      d_q     <= '0;
      l_q     <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      l_q     <= l_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    l_d     = l_q;
    wait_d  = wait_q;
    busy    = 1'b0;
    done    = 1'b0;
    TF_ren  = 1'b0;
    TF_wen  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          d_d     = '0;
          l_d     = TF_DW'(1);
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        busy = 1'b1;
        if (!stall) begin
          TF_ren  = 1'b1;
          wait_d  = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The multiplier pipeline keeps running, so stall is deliberately ignored here.
        busy   = 1'b1;
        wait_d = wait_q + 8'd1;
        if (wait_q == 8'(MUL_LAT - 1)) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        busy = 1'b1;
        if (!stall) begin
          TF_wen = 1'b1;
          if (d_q < TF_DW'(IT_DEPTH)) begin
            d_d     = d_q + TF_DW'(1);
            state_d = ST_READ;
          end else if (l_q < TF_DW'(STAGE_NUM)) begin
            d_d     = '0;
            l_d     = l_q + TF_DW'(1);
            state_d = ST_READ;
          end else begin
            d_d     = '0;
            l_d     = '0;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  tf_idx_rotate u_idx_rotate (
    .l_i   (l_q),
    .idx_o (idx_w)
  );

  genvar gi;
  generate
    for (gi = 0; gi < TF_BANK; gi++) begin : g_gate
      assign idx_g[gi] = busy ? idx_w[gi] : '0;
    end
  endgenerate

  assign it_depth_cnt = busy ? d_q : '0;
  assign l            = busy ? l_q : '0;
  assign idx1  = idx_g[0];
  assign idx2  = idx_g[1];
  assign idx3  = idx_g[2];
  assign idx4  = idx_g[3];
  assign idx5  = idx_g[4];
  assign idx6  = idx_g[5];
  assign idx7  = idx_g[6];
  assign idx8  = idx_g[7];
  assign idx9  = idx_g[8];
  assign idx10 = idx_g[9];
  assign idx11 = idx_g[10];
  assign idx12 = idx_g[11];
  assign idx13 = idx_g[12];
  assign idx14 = idx_g[13];
  assign idx15 = idx_g[14];

`ifdef TF_GEN_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      perf_q <= '0;
    end else if ((state_q == ST_READ || state_q == ST_WRITE) && stall && perf_q != 32'hFFFF_FFFF) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_q;
`endif
endmodule
